// File: rtl/exe_wb_unit_if.sv
// Dispatch, memory and write-back signal bundle for exe_wb_unit.
// The master side is the dispatcher/memory model; the slave side is the unit itself.
interface exe_wb_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int SB_SIZE_WIDTH = 4,
  parameter int REG_WIDTH     = 5,
  parameter int OPT_WIDTH     = 7,
  parameter int FUNCT_WIDTH   = 3
);
  logic                     exe_valid;
  logic                     exe_dest;
  logic [SB_SIZE_WIDTH-1:0] exe_pos;
  logic [OPT_WIDTH-1:0]     exe_opt;
  logic [FUNCT_WIDTH-1:0]   exe_funct;
  logic [REG_WIDTH-1:0]     exe_rd;
  logic [DATA_WIDTH-1:0]    exe_imm;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;

  logic                     mem_req;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [3:0]               mem_wmask;
  logic                     mem_ready;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  logic                     wb_valid;
  logic [SB_SIZE_WIDTH-1:0] wb_pos;
  logic [REG_WIDTH-1:0]     wb_rd;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     wb_we;
  logic                     br_valid;
  logic                     br_taken;
  logic                     err;

  modport master (
    output exe_valid, exe_dest, exe_pos, exe_opt, exe_funct, exe_rd, exe_imm,
           rs1_data, rs2_data, mem_ready, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
           wb_valid, wb_pos, wb_rd, wb_data, wb_we, br_valid, br_taken, err
  );

  modport slave (
    input  exe_valid, exe_dest, exe_pos, exe_opt, exe_funct, exe_rd, exe_imm,
           rs1_data, rs2_data, mem_ready, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
           wb_valid, wb_pos, wb_rd, wb_data, wb_we, br_valid, br_taken, err
  );
endinterface

// File: rtl/exe_wb_unit.sv
// Execution/write-back responder: single-cycle ALU, one outstanding memory transaction,
// and a fair two-way arbiter returning one completion per cycle to the scoreboard.
module exe_wb_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int SB_SIZE_WIDTH = 4,
  parameter int REG_WIDTH     = 5,
  parameter int OPT_WIDTH     = 7,
  parameter int FUNCT_WIDTH   = 3
) (
  input  logic        clk,
  input  logic        rst,
  exe_wb_unit_if.slave bus
);
  localparam logic [OPT_WIDTH-1:0] OP_I = OPT_WIDTH'(7'b0010011);
  localparam logic [OPT_WIDTH-1:0] OP_R = OPT_WIDTH'(7'b0110011);
  localparam logic [OPT_WIDTH-1:0] OP_B = OPT_WIDTH'(7'b1100011);
  localparam logic [OPT_WIDTH-1:0] OP_L = OPT_WIDTH'(7'b0000011);
  localparam logic [OPT_WIDTH-1:0] OP_S = OPT_WIDTH'(7'b0100011);

  typedef enum logic [1:0] {LS_IDLE, LS_REQ, LS_DONE} ls_state_t;
  typedef enum logic [1:0] {KIND_REG, KIND_BR, KIND_NONE} wb_kind_t;

  ls_state_t ls_state, ls_next;

  logic                     alu_v, alu_taken;
  logic [SB_SIZE_WIDTH-1:0] alu_pos;
  logic [REG_WIDTH-1:0]     alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  wb_kind_t                 alu_kind;

  logic [SB_SIZE_WIDTH-1:0] ls_pos;
  logic [REG_WIDTH-1:0]     ls_rd;
  logic [FUNCT_WIDTH-1:0]   ls_funct;
  logic                     ls_store;
  logic [DATA_WIDTH-1:0]    ls_addr, ls_wdata, ls_data;
  logic [3:0]               ls_mask;
  logic                     last_ls;

  logic                     wb_valid_q, wb_we_q, br_valid_q, br_taken_q, err_q;
  logic [SB_SIZE_WIDTH-1:0] wb_pos_q;
  logic [REG_WIDTH-1:0]     wb_rd_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;

  // ALU datapath, evaluated on the dispatch-cycle operands
  logic [DATA_WIDTH-1:0]        op_a, op_b, alu_res;
  logic signed [DATA_WIDTH-1:0] sra_res;
  logic [4:0]                   shamt;
  logic                         lt_s, lt_u, eq, alu_br, alu_bad;
  wb_kind_t                     alu_k;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_a    = bus.rs1_data;
    op_b    = (bus.exe_opt == OP_R || bus.exe_opt == OP_B) ? bus.rs2_data : bus.exe_imm;
    shamt   = op_b[4:0];
    sra_res = $signed(op_a) >>> shamt;
    lt_s    = $signed(op_a) < $signed(op_b);
    lt_u    = op_a < op_b;
    eq      = op_a == op_b;
    alu_res = '0;
    alu_br  = 1'b0;
    alu_bad = 1'b0;
    alu_k   = KIND_REG;
    if (bus.exe_opt == OP_I || bus.exe_opt == OP_R) begin
      case (bus.exe_funct)
        3'd0:    alu_res = (bus.exe_opt == OP_R && bus.exe_imm[10]) ? op_a - op_b : op_a + op_b;
        3'd1:    alu_res = op_a << shamt;
        3'd2:    alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
        3'd3:    alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
        3'd4:    alu_res = op_a ^ op_b;
        3'd5:    alu_res = bus.exe_imm[10] ? sra_res : op_a >> shamt;
        3'd6:    alu_res = op_a | op_b;
        default: alu_res = op_a & op_b;
      endcase
    end else if (bus.exe_opt == OP_B) begin
      alu_k = KIND_BR;
      case (bus.exe_funct)
        3'd0:    alu_br = eq;
        3'd1:    alu_br = !eq;
        3'd4:    alu_br = lt_s;
        3'd5:    alu_br = !lt_s;
        3'd6:    alu_br = lt_u;
        3'd7:    alu_br = !lt_u;
        default: alu_bad = 1'b1;
      endcase
    end else begin
      alu_k   = KIND_NONE;
      alu_bad = 1'b1;
    end
  end

  // Load/store request formation at dispatch
  logic [DATA_WIDTH-1:0] ls_addr_c, ls_wdata_c;
  logic [3:0]            ls_mask_c;
  logic                  ls_store_c, ls_bad_c;

  always_comb begin
    ls_addr_c  = bus.rs1_data + bus.exe_imm;
    ls_store_c = (bus.exe_opt == OP_S);
    ls_wdata_c = '0;
    ls_mask_c  = '0;
    ls_bad_c   = !(bus.exe_opt == OP_L || ls_store_c);
    if (ls_store_c) begin
      case (bus.exe_funct)
        3'd0: begin ls_wdata_c = {4{bus.rs2_data[7:0]}};  ls_mask_c = 4'b0001 << ls_addr_c[1:0]; end
        3'd1: begin ls_wdata_c = {2{bus.rs2_data[15:0]}}; ls_mask_c = 4'b0011 << ls_addr_c[1:0]; end
        3'd2: begin ls_wdata_c = bus.rs2_data;            ls_mask_c = 4'b1111; end
        default: ls_bad_c = 1'b1;
      endcase
    end else begin
      case (bus.exe_funct)
        3'd0, 3'd4: ;
        3'd1, 3'd5: ls_bad_c = ls_bad_c | ls_addr_c[0];
        3'd2:       ls_bad_c = ls_bad_c | (ls_addr_c[1:0] != 2'b00);
        default:    ls_bad_c = 1'b1;
      endcase
    end
  end

  // Misaligned loads simply take the lanes that remain after shifting within the word
  logic [DATA_WIDTH-1:0] rd_shift, load_val;

  always_comb begin
    rd_shift = bus.mem_rdata >> {ls_addr[1:0], 3'b000};
    case (ls_funct)
      3'd0:    load_val = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    load_val = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    load_val = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      3'd5:    load_val = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Arbitration and free-on-grant acceptance
  logic ls_ready, grant_alu, grant_ls, alu_free, ls_free, alu_dispatch, ls_dispatch;

  assign ls_ready     = (ls_state == LS_DONE);
  assign grant_alu    = alu_v && (!ls_ready || last_ls);
  assign grant_ls     = ls_ready && !grant_alu;
  assign alu_free     = !alu_v || grant_alu;
  assign ls_free      = (ls_state == LS_IDLE) || (ls_ready && grant_ls);
  assign alu_dispatch = bus.exe_valid && !bus.exe_dest && alu_free;
  assign ls_dispatch  = bus.exe_valid && bus.exe_dest && ls_free;

  always_ff @(posedge clk) begin
    if (rst) ls_state <= LS_IDLE;
    else     ls_state <= ls_next;
  end

  always_comb begin
    ls_next       = ls_state;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    case (ls_state)
      LS_IDLE: if (ls_dispatch) ls_next = LS_REQ;
      LS_REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = ls_store;
        bus.mem_addr  = {ls_addr[DATA_WIDTH-1:2], 2'b00};
        bus.mem_wdata = ls_wdata;
        bus.mem_wmask = ls_mask;
        if (bus.mem_ready) ls_next = LS_DONE;
      end
      LS_DONE: if (grant_ls) ls_next = ls_dispatch ? LS_REQ : LS_IDLE;
      default: ls_next = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      alu_v <= 1'b0; alu_taken <= 1'b0; alu_pos <= '0; alu_rd <= '0; alu_data <= '0;
      alu_kind <= KIND_REG;
      ls_pos <= '0; ls_rd <= '0; ls_funct <= '0; ls_store <= 1'b0;
      ls_addr <= '0; ls_wdata <= '0; ls_data <= '0; ls_mask <= '0;
      last_ls <= 1'b1;
      wb_valid_q <= 1'b0; wb_we_q <= 1'b0; br_valid_q <= 1'b0; br_taken_q <= 1'b0;
      wb_pos_q <= '0; wb_rd_q <= '0; wb_data_q <= '0; err_q <= 1'b0;
    end else begin
      wb_valid_q <= grant_alu || grant_ls;
      br_valid_q <= grant_alu && (alu_kind == KIND_BR);
      br_taken_q <= grant_alu && (alu_kind == KIND_BR) && alu_taken;
      if (grant_alu) begin
        wb_pos_q  <= alu_pos;
        wb_rd_q   <= alu_rd;
        wb_data_q <= alu_data;
        wb_we_q   <= (alu_kind == KIND_REG) && (alu_rd != '0);
        alu_v     <= 1'b0;
        last_ls   <= 1'b0;
      end else if (grant_ls) begin
        wb_pos_q  <= ls_pos;
        wb_rd_q   <= ls_rd;
        wb_data_q <= ls_data;
        wb_we_q   <= !ls_store && (ls_rd != '0);
        last_ls   <= 1'b1;
      end else begin
        wb_we_q   <= 1'b0;
      end

      if (alu_dispatch) begin
        alu_v     <= 1'b1;
        alu_pos   <= bus.exe_pos;
        alu_kind  <= alu_k;
        alu_taken <= alu_br;
        alu_rd    <= (alu_k == KIND_REG) ? bus.exe_rd : '0;
        alu_data  <= (alu_k == KIND_REG) ? alu_res : '0;
      end

      if (ls_dispatch) begin
        ls_pos   <= bus.exe_pos;
        ls_rd    <= ls_store_c ? '0 : bus.exe_rd;
        ls_funct <= bus.exe_funct;
        ls_store <= ls_store_c;
        ls_addr  <= ls_addr_c;
        ls_wdata <= ls_wdata_c;
        ls_mask  <= ls_mask_c;
      end

      if (ls_state == LS_REQ && bus.mem_ready)
        ls_data <= ls_store ? '0 : load_val;

      if ((bus.exe_valid && !(bus.exe_dest ? ls_free : alu_free)) ||
          (alu_dispatch && alu_bad) || (ls_dispatch && ls_bad_c))
        err_q <= 1'b1;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_pos   = wb_pos_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.br_valid = br_valid_q;
  assign bus.br_taken = br_taken_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_exe_wb_unit.sv
// Directed bench for exe_wb_unit: expected completions are queued at dispatch and
// a negedge monitor compares every write-back the unit presents.
module tb_exe_wb_unit;
  localparam logic [6:0] OP_I = 7'b0010011, OP_R = 7'b0110011, OP_B = 7'b1100011;
  localparam logic [6:0] OP_L = 7'b0000011, OP_S = 7'b0100011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_wb_unit_if bus ();
  exe_wb_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [3:0]  pos;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we, br, taken;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_wb(input logic [3:0] pos, input logic [4:0] rd, input logic [31:0] data,
                           input logic we, input logic br, input logic taken);
    exp_t e;
    e.pos = pos; e.rd = rd; e.data = data; e.we = we; e.br = br; e.taken = taken;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.wb_valid) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {28'd0, bus.wb_pos}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_pos",   {28'd0, bus.wb_pos}, {28'd0, e.pos});
        check("wb_rd",    {27'd0, bus.wb_rd},  {27'd0, e.rd});
        check("wb_data",  bus.wb_data, e.data);
        check("wb_we",    {31'd0, bus.wb_we},    {31'd0, e.we});
        check("br_valid", {31'd0, bus.br_valid}, {31'd0, e.br});
        check("br_taken", {31'd0, bus.br_taken}, {31'd0, e.taken});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic dest, input logic [3:0] pos, input logic [6:0] opt,
                       input logic [2:0] funct, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.exe_valid = 1'b1; bus.exe_dest = dest; bus.exe_pos = pos; bus.exe_opt = opt;
    bus.exe_funct = funct; bus.exe_rd = rd; bus.exe_imm = imm;
    bus.rs1_data = rs1; bus.rs2_data = rs2;
  endtask

  task automatic dispatch(input logic dest, input logic [3:0] pos, input logic [6:0] opt,
                          input logic [2:0] funct, input logic [4:0] rd, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2);
    drive(dest, pos, opt, funct, rd, imm, rs1, rs2);
    tick();
    bus.exe_valid = 1'b0;
  endtask

  // Answers the pending memory request after 'waits' stall cycles; optionally dispatches an
  // ALU op on the ready edge, or a second LS op while the first is still outstanding.
  task automatic mem_respond(input int waits, input logic [31:0] rdata, input logic exp_we,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_mask, input logic with_alu,
                             input logic [3:0] apos, input logic [4:0] ard,
                             input logic [31:0] aimm, input logic with_drop);
    int cyc = 0;
    while (!bus.mem_req && cyc < 16) begin
      tick();
      cyc++;
    end
    check("mem_req",   {31'd0, bus.mem_req}, 32'd1);
    check("mem_we",    {31'd0, bus.mem_we}, {31'd0, exp_we});
    check("mem_addr",  bus.mem_addr, exp_addr);
    check("mem_wdata", bus.mem_wdata, exp_wdata);
    check("mem_wmask", {28'd0, bus.mem_wmask}, {28'd0, exp_mask});
    for (int i = 0; i < waits; i++) begin
      if (with_drop && i == 0) drive(1'b1, 4'd13, OP_L, 3'd0, 5'd13, 32'd0, 32'h3000, 32'd0);
      tick();
      bus.exe_valid = 1'b0;
      check("mem_req_hold",  {31'd0, bus.mem_req}, 32'd1);
      check("mem_addr_hold", bus.mem_addr, exp_addr);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    if (with_alu) drive(1'b0, apos, OP_I, 3'd0, ard, aimm, 32'd0, 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    bus.exe_valid = 1'b0;
    check("mem_req_release", {31'd0, bus.mem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.exe_valid = 1'b0; bus.exe_dest = 1'b0; bus.exe_pos = '0; bus.exe_opt = '0;
    bus.exe_funct = '0; bus.exe_rd = '0; bus.exe_imm = '0; bus.rs1_data = '0;
    bus.rs2_data = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    settle(2);
    check("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_br_valid", {31'd0, bus.br_valid}, 32'd0);
    check("rst_err",      {31'd0, bus.err}, 32'd0);
    check("rst_wb_data",  bus.wb_data, 32'd0);
    rst = 1'b0;
    tick();

    // ADDI x5,x0,-1 with the two-cycle latency observed directly
    expect_wb(4'd3, 5'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd3, OP_I, 3'd0, 5'd5, 32'hFFFF_FFFF, 32'd0, 32'd0);
    check("alu_lat_e0", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    check("alu_lat_e1", {31'd0, bus.wb_valid}, 32'd1);
    settle(2);

    // Back-to-back ALU ops exercise free-on-grant
    expect_wb(4'd4, 5'd7, 32'd7, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd4, OP_R, 3'd0, 5'd7, 32'h0000_0400, 32'd10, 32'd3);
    expect_wb(4'd5, 5'd7, 32'd13, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd5, OP_R, 3'd0, 5'd7, 32'd0, 32'd10, 32'd3);
    expect_wb(4'd6, 5'd6, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd6, OP_I, 3'd5, 5'd6, 32'h0000_0404, 32'h8000_0000, 32'd0);
    expect_wb(4'd1, 5'd8, 32'd1, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd1, OP_R, 3'd3, 5'd8, 32'd0, 32'd1, 32'hFFFF_FFFF);
    expect_wb(4'd2, 5'd8, 32'd0, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd2, OP_R, 3'd2, 5'd8, 32'd0, 32'd1, 32'hFFFF_FFFF);
    expect_wb(4'd0, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0);
    dispatch(1'b0, 4'd0, OP_I, 3'd0, 5'd0, 32'd5, 32'd0, 32'd0);
    settle(3);

    // LB from lane 2 with sign extension, three-cycle memory latency
    expect_wb(4'd6, 5'd4, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
    dispatch(1'b1, 4'd6, OP_L, 3'd0, 5'd4, 32'd2, 32'h1000, 32'd0);
    mem_respond(2, 32'h0080_0000, 1'b0, 32'h1000, 32'd0, 4'b0000, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    settle(3);

    // SB to the top byte lane
    expect_wb(4'd7, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    dispatch(1'b1, 4'd7, OP_S, 3'd0, 5'd9, 32'd3, 32'h1000, 32'h1234_5678);
    mem_respond(0, 32'd0, 1'b1, 32'h1000, 32'h7878_7878, 4'b1000, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    settle(3);

    // BLT taken, BLTU not taken on the same operands
    expect_wb(4'd2, 5'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    dispatch(1'b0, 4'd2, OP_B, 3'd4, 5'd3, 32'd0, 32'hFFFF_FFFF, 32'd1);
    expect_wb(4'd3, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    dispatch(1'b0, 4'd3, OP_B, 3'd6, 5'd3, 32'd0, 32'hFFFF_FFFF, 32'd1);
    settle(3);
    check("err_clean", {31'd0, bus.err}, 32'd0);

    // Both hold regs valid together after an ALU grant: LS wins first
    expect_wb(4'd8, 5'd10, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    expect_wb(4'd9, 5'd11, 32'd7, 1'b1, 1'b0, 1'b0);
    dispatch(1'b1, 4'd8, OP_L, 3'd2, 5'd10, 32'd0, 32'h2000, 32'd0);
    mem_respond(1, 32'hCAFE_F00D, 1'b0, 32'h2000, 32'd0, 4'b0000, 1'b1, 4'd9, 5'd11, 32'd7, 1'b0);
    settle(3);

    // SW alone leaves LS as last grant
    expect_wb(4'd14, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    dispatch(1'b1, 4'd14, OP_S, 3'd2, 5'd0, 32'd4, 32'h2000, 32'hDEAD_BEEF);
    mem_respond(0, 32'd0, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b1111, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    settle(3);

    // Conflict again: ALU wins first this time
    expect_wb(4'd11, 5'd14, 32'h55, 1'b1, 1'b0, 1'b0);
    expect_wb(4'd10, 5'd13, 32'h1122_3344, 1'b1, 1'b0, 1'b0);
    dispatch(1'b1, 4'd10, OP_L, 3'd2, 5'd13, 32'd4, 32'h2000, 32'd0);
    mem_respond(1, 32'h1122_3344, 1'b0, 32'h2004, 32'd0, 4'b0000, 1'b1, 4'd11, 5'd14, 32'h55, 1'b0);
    settle(3);

    // Misaligned LW: truncated lanes and err set
    expect_wb(4'd0, 5'd9, 32'h00AA_BBCC, 1'b1, 1'b0, 1'b0);
    dispatch(1'b1, 4'd0, OP_L, 3'd2, 5'd9, 32'd1, 32'h1000, 32'd0);
    mem_respond(0, 32'hAABB_CCDD, 1'b0, 32'h1000, 32'd0, 4'b0000, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0);
    settle(3);
    check("err_misaligned", {31'd0, bus.err}, 32'd1);

    // Reset while a request is outstanding abandons it with no write-back
    dispatch(1'b1, 4'd5, OP_L, 3'd2, 5'd1, 32'd0, 32'h4000, 32'd0);
    check("req_before_rst", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst_req_drop",   {31'd0, bus.mem_req}, 32'd0);
    check("rst_wb_quiet",   {31'd0, bus.wb_valid}, 32'd0);
    check("rst_err_clear",  {31'd0, bus.err}, 32'd0);
    rst = 1'b0;
    settle(3);
    expect_wb(4'd1, 5'd2, 32'h10, 1'b1, 1'b0, 1'b0);
    dispatch(1'b0, 4'd1, OP_I, 3'd0, 5'd2, 32'h10, 32'd0, 32'd0);
    settle(3);

    // Second LS dispatch while busy is dropped and flagged
    expect_wb(4'd12, 5'd12, 32'h0000_00F0, 1'b1, 1'b0, 1'b0);
    dispatch(1'b1, 4'd12, OP_L, 3'd4, 5'd12, 32'd0, 32'h3000, 32'd0);
    mem_respond(2, 32'h0000_00F0, 1'b0, 32'h3000, 32'd0, 4'b0000, 1'b0, 4'd0, 5'd0, 32'd0, 1'b1);
    settle(4);
    check("err_busy_drop", {31'd0, bus.err}, 32'd1);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
